// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the register-file write-back arbiter slice.
//   - Default widths/counts for the arbiter parameters.
//   - Source index constants identifying each write-back requester.
//   - ptr_width(): width of a pointer that indexes n sources (min 1 bit).
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int NUM_SRC_DEF = 3;
    localparam int AW_DEF      = 5;
    localparam int DW_W_DEF    = 32;

    localparam int SRC_ALU     = 0;
    localparam int SRC_LOAD    = 1;
    localparam int SRC_MULDIV  = 2;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin grant selection with a registered rotation pointer.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset (pointer returns to source 0)
//   stall  - blocks every grant while high; pointer holds
//   valid  - per-source request
//   grant  - one-hot (or zero) combinational grant: first valid source
//            scanning upward from the pointer, wrapping modulo NUM_SRC
// A grant always coincides with a valid request, so every grant is a
// completed transfer and advances the pointer past the granted source.
// ---------------------------------------------------------------------------
module rr_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    localparam int PW     = ptr_width(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic [NUM_SRC-1:0] valid,
    output logic [NUM_SRC-1:0] grant
);

    logic [PW-1:0] rr_ptr_reg;
    logic [PW-1:0] rr_ptr_next;
    logic          found;

    always_comb begin
        int idx;
        int nxt;
        grant       = '0;
        found       = 1'b0;
        rr_ptr_next = rr_ptr_reg;
        idx         = 0;
        nxt         = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            // Candidate k positions after the pointer, wrapped into range.
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (!found && !stall && valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                nxt        = (idx == NUM_SRC - 1) ? 0 : idx + 1;
                rr_ptr_next = PW'(nxt);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= '0;
        end else if (found) begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
// Arbitrates register-file write-back between NUM_SRC requesters
// (ALU, LOAD, MULDIV), registers the winner onto the write port one cycle
// after the transfer, and offers bypass data for two read ports.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   stall                 - blocks all grants
//   req_valid/addr/data   - per-source request, packed source-major
//   req_ready             - per-source grant (one-hot or zero)
//   rf_we/rf_wa/rf_dw     - register-file write port (1-cycle latency)
//   fwd_addr1/2           - read addresses for bypass lookup
//   fwd_hit1/2, fwd_data1/2 - bypass hit and data (0 when no hit)
// Writes to register 0 are accepted but never raise rf_we.
// ---------------------------------------------------------------------------
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW_W    = DW_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall,
    input  logic [NUM_SRC-1:0]      req_valid,
    input  logic [NUM_SRC*AW-1:0]   req_addr,
    input  logic [NUM_SRC*DW_W-1:0] req_data,
    output logic [NUM_SRC-1:0]      req_ready,
    output logic                    rf_we,
    output logic [AW-1:0]           rf_wa,
    output logic [DW_W-1:0]         rf_dw,
    input  logic [AW-1:0]           fwd_addr1,
    input  logic [AW-1:0]           fwd_addr2,
    output logic                    fwd_hit1,
    output logic                    fwd_hit2,
    output logic [DW_W-1:0]         fwd_data1,
    output logic [DW_W-1:0]         fwd_data2
);

    logic [NUM_SRC-1:0] grant;
    logic               xfer;
    logic [AW-1:0]      addr_masked [NUM_SRC];
    logic [DW_W-1:0]    data_masked [NUM_SRC];
    logic [AW-1:0]      sel_addr;
    logic [DW_W-1:0]    sel_data;

    logic               rf_we_reg;
    logic [AW-1:0]      rf_wa_reg;
    logic [DW_W-1:0]    rf_dw_reg;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (stall),
        .valid (req_valid),
        .grant (grant)
    );

    assign req_ready = grant;
    assign xfer      = |grant;

    // Grant is one-hot, so an OR of grant-masked lanes is the selected lane.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_mask
            assign addr_masked[gi] = grant[gi] ? req_addr[gi*AW +: AW]     : '0;
            assign data_masked[gi] = grant[gi] ? req_data[gi*DW_W +: DW_W] : '0;
        end
    endgenerate

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sel_addr = sel_addr | addr_masked[i];
            sel_data = sel_data | data_masked[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_reg <= 1'b0;
            rf_wa_reg <= '0;
            rf_dw_reg <= '0;
        end else if (xfer) begin
            rf_we_reg <= (sel_addr != '0);
            rf_wa_reg <= sel_addr;
            rf_dw_reg <= sel_data;
        end else begin
            rf_we_reg <= 1'b0;
        end
    end

    assign rf_we = rf_we_reg;
    assign rf_wa = rf_wa_reg;
    assign rf_dw = rf_dw_reg;

    // Bypass sees only the write currently on the port.
    assign fwd_hit1  = rf_we_reg && (fwd_addr1 == rf_wa_reg);
    assign fwd_hit2  = rf_we_reg && (fwd_addr2 == rf_wa_reg);
    assign fwd_data1 = fwd_hit1 ? rf_dw_reg : '0;
    assign fwd_data2 = fwd_hit2 ? rf_dw_reg : '0;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            stall = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            rf_we;
    logic [AW-1:0]   rf_wa;
    logic [DW-1:0]   rf_dw;
    logic [AW-1:0]   fwd_addr1 = '0;
    logic [AW-1:0]   fwd_addr2 = '0;
    logic            fwd_hit1, fwd_hit2;
    logic [DW-1:0]   fwd_data1, fwd_data2;

    int checks = 0;
    int errors = 0;

    // Reference model: what the write port should show and whose turn it is.
    int            m_ptr = 0;
    bit            m_we  = 1'b0;
    logic [AW-1:0] m_wa  = '0;
    logic [DW-1:0] m_dw  = '0;
    int            last_grant;
    logic [N-1:0]  obs_ready;

    rf_wb_arbiter #(.NUM_SRC(N), .AW(AW), .DW_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .rf_we(rf_we), .rf_wa(rf_wa), .rf_dw(rf_dw),
        .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whose turn: sources listed in priority order starting at the pointer.
    function automatic int model_grant();
        int order[$];
        if (stall) return -1;
        for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
        foreach (order[j]) if (req_valid[order[j]]) return order[j];
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_we = 1'b0; m_wa = '0; m_dw = '0;
    endtask

    // One clock: called just after a rising edge with inputs already driven.
    task automatic cycle();
        int g;
        logic [AW-1:0] a;
        @(negedge clk);
        g = model_grant();
        obs_ready = req_ready;
        check("req_ready", req_ready, (g < 0) ? '0 : (64'd1 << g));
        check("rf_we", rf_we, m_we);
        check("rf_wa", rf_wa, m_wa);
        check("rf_dw", rf_dw, m_dw);
        check("fwd_hit1", fwd_hit1, m_we && (fwd_addr1 == m_wa));
        check("fwd_hit2", fwd_hit2, m_we && (fwd_addr2 == m_wa));
        check("fwd_data1", fwd_data1, (m_we && fwd_addr1 == m_wa) ? m_dw : '0);
        check("fwd_data2", fwd_data2, (m_we && fwd_addr2 == m_wa) ? m_dw : '0);
        @(posedge clk);
        if (g >= 0) begin
            a     = req_addr[g*AW +: AW];
            m_wa  = a;
            m_dw  = req_data[g*DW +: DW];
            m_we  = (a != 0);
            m_ptr = (g + 1) % N;
        end else begin
            m_we = 1'b0;
        end
        last_grant = g;
        #1;
        $display("cyc t=%0t stall=%0b valid=%b ready=%b we=%0b wa=%0d dw=%h",
                 $time, stall, req_valid, obs_ready, rf_we, rf_wa, rf_dw);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        req_valid = '0;
        #1;
        check("rst_we", rf_we, 1'b0);
        check("rst_wa", rf_wa, '0);
        check("rst_dw", rf_dw, '0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0]  pend;
    logic [AW-1:0] paddr [N];
    logic [DW-1:0] pdata [N];
    int            grants[$];

    initial begin
        // Reset state
        #3;
        check("reset_ready", req_ready, '0);
        check("reset_we", rf_we, 1'b0);
        check("reset_wa", rf_wa, '0);
        check("reset_dw", rf_dw, '0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single ALU write
        req_valid = 3'b001;
        req_addr[0 +: AW] = 5'd5;
        req_data[0 +: DW] = 32'hDEADBEEF;
        cycle();
        check("alu_ready", obs_ready, 3'b001);
        req_valid = '0;
        check("alu_we", rf_we, 1'b1);
        check("alu_wa", rf_wa, 5'd5);
        check("alu_dw", rf_dw, 32'hDEADBEEF);
        cycle();
        check("alu_we_drop", rf_we, 1'b0);

        // All sources valid from reset: strict rotation
        do_reset();
        for (int s = 0; s < N; s++) begin
            req_addr[s*AW +: AW] = AW'(10 + s);
            req_data[s*DW +: DW] = 32'hA000_0000 + s;
        end
        req_valid = 3'b111;
        grants.delete();
        for (int c = 0; c < 6; c++) begin
            cycle();
            grants.push_back(last_grant);
            check("rot_we", rf_we, 1'b1);
        end
        for (int c = 0; c < 6; c++) check("rot_order", grants[c], c % 3);
        req_valid = '0;
        cycle();
        check("rot_we_end", rf_we, 1'b0);

        // LOAD write to register 0: accepted, no write enable
        req_valid = 3'b010;
        req_addr[1*AW +: AW] = '0;
        req_data[1*DW +: DW] = 32'h1234;
        cycle();
        check("r0_ready", obs_ready, 3'b010);
        check("r0_we", rf_we, 1'b0);
        req_valid = 3'b111;
        cycle();
        check("r0_ptr2", obs_ready, 3'b100);

        // Stall with everything valid
        req_valid = 3'b001;
        cycle();
        req_valid = 3'b111;
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("stall_ready", obs_ready, '0);
        end
        check("stall_we", rf_we, 1'b0);
        stall = 1'b0;
        cycle();
        check("stall_resume", obs_ready, 3'b010);
        req_valid = '0;
        cycle();

        // Bypass on the write cycle
        req_valid = 3'b001;
        req_addr[0 +: AW] = 5'd7;
        req_data[0 +: DW] = 32'h55;
        cycle();
        req_valid = '0;
        fwd_addr1 = 5'd7;
        fwd_addr2 = 5'd8;
        #1;
        check("byp_hit1", fwd_hit1, 1'b1);
        check("byp_data1", fwd_data1, 32'h55);
        check("byp_hit2", fwd_hit2, 1'b0);
        check("byp_data2", fwd_data2, '0);
        cycle();

        // Reset between transfer and write-back
        req_valid = 3'b010;
        req_addr[1*AW +: AW] = 5'd9;
        req_data[1*DW +: DW] = 32'hCAFE;
        cycle();
        check("mid_we_pre", rf_we, 1'b1);
        rst_n = 1'b0;
        req_valid = '0;
        model_reset();
        #1;
        check("mid_we_async", rf_we, 1'b0);
        check("mid_wa_async", rf_wa, '0);
        #1 rst_n = 1'b1;
        cycle();
        check("mid_no_write", rf_we, 1'b0);
        req_valid = 3'b111;
        cycle();
        check("mid_ptr0", obs_ready, 3'b001);
        req_valid = '0;
        cycle();

        // Randomized traffic honouring the hold-until-granted rule
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            for (int s = 0; s < N; s++) begin
                if (!pend[s] && ($urandom_range(0, 9) < 4)) begin
                    pend[s]  = 1'b1;
                    paddr[s] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
                    pdata[s] = $urandom;
                end
                req_addr[s*AW +: AW] = pend[s] ? paddr[s] : AW'($urandom);
                req_data[s*DW +: DW] = pend[s] ? pdata[s] : $urandom;
            end
            req_valid = pend;
            stall     = ($urandom_range(0, 4) == 0);
            fwd_addr1 = $urandom_range(0, 1) ? m_wa : AW'($urandom);
            fwd_addr2 = $urandom_range(0, 3) == 0 ? m_wa : AW'($urandom);
            cycle();
            if (last_grant >= 0) pend[last_grant] = 1'b0;
        end
        stall = 1'b0;
        req_valid = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3: number of write-back requesters (0=ALU, 1=LOAD, 2=MULDIV).
REQ-002 SHALL have parameter AW, default 5: register address width.
REQ-003 SHALL have parameter DW_W, default 32: register data width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port stall  input  1  when high, blocks all grants.
REQ-007 SHALL have port req_valid  input  NUM_SRC  per-source write request.
REQ-008 SHALL have port req_addr  input  NUM_SRC*AW  per-source destination register.
REQ-009 SHALL have port req_data  input  NUM_SRC*DW_W  per-source write data.
REQ-010 SHALL have port req_ready  output  NUM_SRC  per-source grant, one-hot or zero.
REQ-011 SHALL have port rf_we  output  1  register file write enable.
REQ-012 SHALL have port rf_wa  output  AW  register file write address.
REQ-013 SHALL have port rf_dw  output  DW_W  register file write data.
REQ-014 SHALL have ports fwd_addr1, fwd_addr2  input  AW each  read-port addresses for bypass lookup.
REQ-015 SHALL have ports fwd_hit1, fwd_hit2  output  1 each  bypass hit per read port.
REQ-016 SHALL have ports fwd_data1, fwd_data2  output  DW_W each  bypass data per read port.

Function
REQ-017 SHALL complete a transfer for source i in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-018 SHALL drive req_ready combinationally and one-hot: the first valid source scanning from rr_ptr upward, modulo NUM_SRC.
REQ-019 SHALL drive req_ready to all-zero when stall=1 or no source is valid.
REQ-020 SHALL update rr_ptr to (i+1) mod NUM_SRC on a transfer from source i; otherwise rr_ptr SHALL hold.
REQ-021 SHALL register the granted addr/data onto rf_wa/rf_dw, giving a write-back latency of exactly 1 cycle from the transfer.
REQ-022 SHALL set rf_we=1 in the cycle after a transfer whose addr!=0, and rf_we=0 in every other cycle.
REQ-023 SHALL accept a transfer whose addr==0 but keep rf_we=0; rf_wa/rf_dw MAY update.
REQ-024 SHALL hold rf_wa/rf_dw at their previous values when there is no transfer.
REQ-025 SHALL set fwd_hitN = rf_we && (fwd_addrN == rf_wa), purely combinational; fwd_dataN = rf_dw on a hit, else 0.
REQ-026 SHALL require a requester to hold addr/data stable while its valid is high and not granted; valid SHALL NOT be dropped before grant.
REQ-027 SHALL give a stall asserted in the same cycle as valid priority, so that no transfer occurs; the pointer SHALL be unchanged.
REQ-028 SHALL guarantee that a continuously valid requester is granted within NUM_SRC cycles while stall=0 (starvation-free).

Reset
REQ-029 SHALL, on rst_n low and asynchronously, set rr_ptr=0, rf_we=0, rf_wa=0 and rf_dw=0.
REQ-030 SHALL let outputs react to reset without waiting for clk.
REQ-031 SHALL drop an in-flight write when reset asserts mid-operation; no rf_we pulse SHALL follow reset release.
REQ-032 SHALL make its first grant after reset release on the first rising edge with rst_n high.

Structure
REQ-033 SHALL place NUM_SRC, AW, DW_W defaults and the source-index constants (SRC_ALU=0, SRC_LOAD=1, SRC_MULDIV=2) in a shared package rf_pkg.
REQ-034 SHALL implement grant selection plus rr_ptr in one sub-module rr_arbiter; mux, output register and bypass logic SHALL sit in the top.

Verification
REQ-035 SHALL verify: single ALU request addr=5, data=0xDEADBEEF -> req_ready=001 that cycle; next cycle rf_we=1, rf_wa=5, rf_dw=0xDEADBEEF.
REQ-036 SHALL verify: all three valid for 6 cycles from reset -> grants 0,1,2,0,1,2; rf_we high for 6 consecutive cycles starting 1 cycle after the first.
REQ-037 SHALL verify: LOAD request addr=0, data=0x1234 -> req_ready[1]=1; rf_we stays 0; rr_ptr advances to 2.
REQ-038 SHALL verify: stall=1 with all sources valid for 3 cycles -> req_ready=000, rf_we=0 and the pointer unchanged; first grant after stall release goes to the prior rr_ptr source.
REQ-039 SHALL verify: a write to addr 7 data 0x55 with fwd_addr1=7, fwd_addr2=8 in the write cycle -> fwd_hit1=1, fwd_data1=0x55, fwd_hit2=0, fwd_data2=0.
REQ-040 SHALL verify: rst_n pulsed low mid-cycle between a transfer and its write-back -> rf_we falls immediately, no write after release, rr_ptr=0.
